// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: signed multiply-accumulate slice with three precision modes, a chained
// shift-accumulate path, optional saturation and a run-time-programmable output pipeline.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   in_valid      sample present this cycle
//   aa, bb        operands (WIDTH)
//   cc            signed addend for non-chained samples (2*WIDTH)
//   mode          00 half x half, 01 half x full, 10 full x full, 11 ignored
//   mac           request chaining onto the accumulator
//   shift_amount  accumulator shift distance for chained samples
//   shift_dir     1 = arithmetic right, 0 = left
//   pipe_stages   output latency; clamped to MAX_PIPE
//   out_valid     out carries a result
//   out           signed result, zero when out_valid = 0
//   ovf           result of this beat saturated or wrapped
module dsp_mac_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SHIFT_BITS = 2,
  parameter int unsigned MAX_PIPE   = 4,
  parameter int unsigned PIPE_BITS  = 3,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      aa,
  input  logic [WIDTH-1:0]      bb,
  input  logic [2*WIDTH-1:0]    cc,
  input  logic [1:0]            mode,
  input  logic                  mac,
  input  logic [SHIFT_BITS-1:0] shift_amount,
  input  logic                  shift_dir,
  input  logic [PIPE_BITS-1:0]  pipe_stages,
  output logic                  out_valid,
  output logic [2*WIDTH-1:0]    out,
  output logic                  ovf
);

  localparam int unsigned HalfW = WIDTH / 2 + 1;
  localparam int unsigned ResW  = 2 * WIDTH;
  localparam int unsigned SumW  = ResW + SHIFT_BITS + 2;

  logic [ResW-1:0]                acc_q, acc_d;
  logic                           mac_prev_q, mac_prev_d;
  logic [PIPE_BITS-1:0]           d_q, d_d;
  logic [MAX_PIPE-1:0]            pv_q, pv_d;
  logic [MAX_PIPE-1:0]            po_q, po_d;
  logic [MAX_PIPE-1:0][ResW-1:0]  pd_q, pd_d;

  logic                    accept, chain, flush, fits;
  logic [PIPE_BITS-1:0]    d_cur;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic signed [ResW-1:0]  a_ext, b_ext, prod;
  logic signed [SumW-1:0]  prod_ext, acc_ext, cc_ext, addend, sum;
  logic [ResW-1:0]         res;
  logic                    res_ovf;
  logic                    tap_v, tap_o;
  logic [ResW-1:0]         tap_d;

  // Datapath: operand selection, product, addend and saturating sum
  always_comb begin
    // rst_n gating keeps the zero-latency path quiet while in reset
    accept = rst_n & in_valid & (mode != 2'b11);
    chain  = mac & mac_prev_q;

    op_a = (mode == 2'b10) ? aa :
           {{(WIDTH - HalfW){aa[HalfW-1]}}, aa[HalfW-1:0]};
    op_b = (mode == 2'b00) ? {{(WIDTH - HalfW){bb[HalfW-1]}}, bb[HalfW-1:0]} : bb;

    a_ext = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    b_ext = {{WIDTH{op_b[WIDTH-1]}}, op_b};
    prod  = a_ext * b_ext;  // true product always fits 2*WIDTH

    prod_ext = {{(SumW - ResW){prod[ResW-1]}}, prod};
    acc_ext  = {{(SumW - ResW){acc_q[ResW-1]}}, acc_q};
    cc_ext   = {{(SumW - ResW){cc[ResW-1]}}, cc};

    if (chain) begin
      addend = shift_dir ? (acc_ext >>> shift_amount) : (acc_ext << shift_amount);
    end else begin
      addend = cc_ext;
    end
    sum = prod_ext + addend;

    // Fits when every bit above the result sign bit equals the sign bit
    fits = (&sum[SumW-1:ResW-1]) | ~(|sum[SumW-1:ResW-1]);
    if (fits) begin
      res     = sum[ResW-1:0];
      res_ovf = 1'b0;
    end else begin
      res_ovf = 1'b1;
      if (SATURATE) begin
        res = sum[SumW-1] ? {1'b1, {(ResW - 1){1'b0}}} : {1'b0, {(ResW - 1){1'b1}}};
      end else begin
        res = sum[ResW-1:0];
      end
    end
  end

  // Latency control and pipeline next state
  always_comb begin
    d_cur = (pipe_stages > PIPE_BITS'(MAX_PIPE)) ? PIPE_BITS'(MAX_PIPE) : pipe_stages;
    // A latency change drops everything in flight
    flush = (d_cur != d_q);

    acc_d      = accept ? res : acc_q;
    mac_prev_d = accept ? mac : mac_prev_q;
    d_d        = d_cur;

    pv_d = '0;
    po_d = '0;
    pd_d = '0;
    for (int i = MAX_PIPE - 1; i >= 1; i--) begin
      pv_d[i] = pv_q[i-1] & ~flush;
      po_d[i] = po_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    pv_d[0] = accept & (d_cur != '0);
    po_d[0] = res_ovf;
    pd_d[0] = res;
  end

  // Output select: combinational at D = 0, otherwise tap stage D-1
  always_comb begin
    tap_v = 1'b0;
    tap_o = 1'b0;
    tap_d = '0;
    for (int i = 0; i < MAX_PIPE; i++) begin
      if (d_cur == PIPE_BITS'(i + 1)) begin
        tap_v = pv_q[i];
        tap_o = po_q[i];
        tap_d = pd_q[i];
      end
    end

    if (d_cur == '0) begin
      out_valid = accept;
      out       = accept ? res : '0;
      ovf       = accept & res_ovf;
    end else begin
      out_valid = tap_v & ~flush;
      out       = out_valid ? tap_d : '0;
      ovf       = out_valid & tap_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mac_prev_q <= 1'b0;
      d_q        <= '0;
      pv_q       <= '0;
      po_q       <= '0;
      pd_q       <= '0;
    end else begin
      acc_q      <= acc_d;
      mac_prev_q <= mac_prev_d;
      d_q        <= d_d;
      pv_q       <= pv_d;
      po_q       <= po_d;
      pd_q       <= pd_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe (WIDTH=16, SHIFT_BITS=2, MAX_PIPE=4, SATURATE=1).
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] aa, bb;
  logic [31:0] cc;
  logic [1:0]  mode;
  logic        mac;
  logic [1:0]  shift_amount;
  logic        shift_dir;
  logic [2:0]  pipe_stages;
  logic        out_valid;
  logic [31:0] out;
  logic        ovf;

  always #5 clk = ~clk;

  dsp_mac_pipe #(
    .WIDTH(16), .SHIFT_BITS(2), .MAX_PIPE(4), .PIPE_BITS(3), .SATURATE(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aa(aa), .bb(bb), .cc(cc),
    .mode(mode), .mac(mac), .shift_amount(shift_amount), .shift_dir(shift_dir),
    .pipe_stages(pipe_stages), .out_valid(out_valid), .out(out), .ovf(ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: scheduled results keyed by the cycle they must appear in
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          ov;
  } beat_t;

  beat_t  pend[$];
  longint m_acc = 0;
  bit     m_mac_prev = 1'b0;
  int     m_d = 0;
  int     cyc_n = 0;

  function automatic longint sx(input logic [31:0] v, input int bits);
    longint x;
    x = longint'(v) & ((64'sd1 <<< bits) - 64'sd1);
    if (x >= (64'sd1 <<< (bits - 1))) x = x - (64'sd1 <<< bits);
    return x;
  endfunction

  // Evaluate the model for the current cycle's inputs and compare outputs
  task automatic cyc();
    int     dn;
    longint a, b, addend, sum;
    logic [31:0] res;
    bit     ov;
    beat_t  e;
    bit     ev, eo;
    logic [31:0] ed;
    #1;
    if (!rst_n) begin
      pend.delete();
      m_acc = 0;
      m_mac_prev = 1'b0;
      m_d = 0;
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out", {32'd0, out}, 64'd0);
      check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
      return;
    end
    dn = (int'(pipe_stages) > 4) ? 4 : int'(pipe_stages);
    if (dn != m_d) pend.delete();
    if (in_valid && mode != 2'd3) begin
      a = (mode == 2'd2) ? sx({16'd0, aa}, 16) : sx({16'd0, aa}, 9);
      b = (mode == 2'd0) ? sx({16'd0, bb}, 9) : sx({16'd0, bb}, 16);
      if (mac && m_mac_prev) begin
        addend = shift_dir ? (m_acc >>> shift_amount) : (m_acc * (64'sd1 <<< shift_amount));
      end else begin
        addend = sx(cc, 32);
      end
      sum = a * b + addend;
      ov = 1'b1;
      if (sum > 64'sd2147483647) res = 32'h7FFF_FFFF;
      else if (sum < -64'sd2147483648) res = 32'h8000_0000;
      else begin
        res = sum[31:0];
        ov = 1'b0;
      end
      e.due = cyc_n + dn;
      e.data = res;
      e.ov = ov;
      pend.push_back(e);
      m_acc = sx(res, 32);
      m_mac_prev = mac;
    end
    m_d = dn;
    ev = 1'b0;
    eo = 1'b0;
    ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      e = pend.pop_front();
      ev = 1'b1;
      ed = e.data;
      eo = e.ov;
    end
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, ev});
    check_eq("out", {32'd0, out}, {32'd0, ed});
    check_eq("ovf", {63'd0, ovf}, {63'd0, eo});
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic step();
    cyc();
    adv();
  endtask

  task automatic set_s(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] c, input logic m);
    in_valid = 1'b1;
    mode = md;
    aa = a;
    bb = b;
    cc = c;
    mac = m;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    aa = '0;
    bb = '0;
    cc = '0;
    mode = 2'd0;
    mac = 1'b0;
    shift_amount = '0;
    shift_dir = 1'b0;
    pipe_stages = '0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Zero latency, full x full: 3 * -4 + 10 = -2
    set_s(2'd2, 16'd3, 16'hFFFC, 32'd10, 1'b0);
    cyc();
    check_eq("t1_out", {32'd0, out}, {32'd0, 32'hFFFF_FFFE});
    check_eq("t1_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t1_ovf", {63'd0, ovf}, 64'd0);
    adv();

    // Latency 2 with a chained left shift
    pipe_stages = 3'd2;
    set_s(2'd2, 16'd2, 16'd3, 32'd5, 1'b1);
    step();
    set_s(2'd2, 16'd1, 16'd1, 32'd0, 1'b1);
    shift_dir = 1'b0;
    shift_amount = 2'd1;
    step();
    in_valid = 1'b0;
    cyc();
    check_eq("t2_first", {32'd0, out}, 64'd11);
    adv();
    cyc();
    check_eq("t2_second", {32'd0, out}, 64'd23);
    adv();

    // Saturation on a chained left shift
    pipe_stages = 3'd0;
    set_s(2'd2, 16'd0, 16'd0, 32'd0, 1'b0);
    step();
    set_s(2'd2, 16'h8000, 16'h8000, 32'd0, 1'b1);
    shift_amount = 2'd2;
    cyc();
    check_eq("t3_first", {32'd0, out}, {32'd0, 32'h4000_0000});
    adv();
    cyc();
    check_eq("t3_sat", {32'd0, out}, {32'd0, 32'h7FFF_FFFF});
    check_eq("t3_ovf", {63'd0, ovf}, 64'd1);
    adv();

    // Half x half, then an ignored mode-11 sample must leave acc and mac_prev alone
    set_s(2'd0, 16'h01FF, 16'h0002, 32'd0, 1'b1);
    shift_amount = 2'd0;
    set_s(2'd2, 16'd0, 16'd0, 32'd0, 1'b0);
    step();
    set_s(2'd0, 16'h01FF, 16'h0002, 32'd0, 1'b1);
    cyc();
    check_eq("t4_half", {32'd0, out}, {32'd0, 32'hFFFF_FFFE});
    adv();
    set_s(2'd3, 16'd5, 16'd5, 32'd77, 1'b0);
    cyc();
    check_eq("t4_rsvd_vld", {63'd0, out_valid}, 64'd0);
    adv();
    set_s(2'd2, 16'd0, 16'd0, 32'd0, 1'b1);
    cyc();
    check_eq("t4_acc_kept", {32'd0, out}, {32'd0, 32'hFFFF_FFFE});
    adv();

    // Reset discards in-flight samples and clears the chain history
    pipe_stages = 3'd4;
    set_s(2'd2, 16'd5, 16'd7, 32'd1, 1'b1);
    step();
    aa = 16'd2;
    step();
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_eq("t5_no_beat", {63'd0, out_valid}, 64'd0);
      adv();
    end
    pipe_stages = 3'd0;
    set_s(2'd2, 16'd1, 16'd1, 32'd100, 1'b1);
    cyc();
    check_eq("t5_unchained", {32'd0, out}, 64'd101);
    adv();

    // Latency change drops the in-flight result
    pipe_stages = 3'd3;
    set_s(2'd2, 16'd3, 16'd3, 32'd0, 1'b0);
    step();
    pipe_stages = 3'd1;
    in_valid = 1'b0;
    step();
    set_s(2'd2, 16'd2, 16'd2, 32'd0, 1'b0);
    step();
    in_valid = 1'b0;
    cyc();
    check_eq("t6_new_d", {32'd0, out}, 64'd4);
    adv();
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      aa = rnd16();
      bb = rnd16();
      cc = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'h7FFF_FF00}
                                       : 32'($urandom);
      mac = ($urandom_range(0, 2) != 0);
      shift_amount = 2'($urandom_range(0, 3));
      shift_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) pipe_stages = 3'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
